xvga_timing: RTL and testbench
==============================

// Module: xvga_timing
// PURPOSE
//  Raster timing source for the 1024x768@60 display path (65 MHz pixel clock). It drives
//  hcount/vcount/hsync/vsync/blank into the graphics renderer. It also emits a one-cycle
//  frame_tick at vblank start so game logic can update grid/player state tear-free.
//  A PIPE_DELAY-deep delay line carries sync/blank to match renderer pixel latency.
// PARAMETERS
//  H_ACTIVE 1024 | H_FP 24 | H_SYNC 136 | H_BP 160   horizontal pixels (H_TOTAL = 1344)
//  V_ACTIVE 768  | V_FP 3  | V_SYNC 6   | V_BP 29    vertical lines (V_TOTAL = 806)
//  PIPE_DELAY    2    cycles of delay on hsync_dly/vsync_dly/blank_dly; legal range 1..8
// PORTS
//  clock        in   1   pixel clock
//  reset_n      in   1   asynchronous, active-low reset
//  run          in   1   1 = advance raster; 0 = freeze every register
//  hcount       out  11  current pixel column, 0..H_TOTAL-1
//  vcount       out  10  current line, 0..V_TOTAL-1
//  hsync        out  1   active-low horizontal sync, aligned with hcount
//  vsync        out  1   active-low vertical sync, aligned with vcount
//  blank        out  1   1 outside the 1024x768 active area
//  hsync_dly    out  1   hsync delayed PIPE_DELAY advancing cycles
//  vsync_dly    out  1   vsync delayed PIPE_DELAY advancing cycles
//  blank_dly    out  1   blank delayed PIPE_DELAY advancing cycles
//  frame_tick   out  1   one-cycle pulse at (hcount==0, vcount==V_ACTIVE)
//  frame_count  out  8   frames completed; wraps 255->0
//  test_pixel   out  12  RGB444 colour-bar pixel (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs are registered. No combinational path from run to any output.
//  - Reset values:
//    - hcount=0, vcount=0, hsync=1, vsync=1, blank=0 (pixel 0,0 is active).
//    - *_dly delay stages: hsync=1, vsync=1, blank=1.
//    - frame_tick=0, frame_count=0, test_pixel=0.
//  - Counter update on a cycle where run=1:
//    - If hcount==H_TOTAL-1: hcount<=0. Then vcount<=0 if vcount==V_TOTAL-1, else vcount+1.
//    - Otherwise hcount<=hcount+1.
//  - hsync, vsync, blank, frame_tick and test_pixel are decoded from the next counter values.
//    They therefore change in the same cycle as the hcount/vcount they describe (zero skew).
//  - hsync=0 iff hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [1048,1183].
//  - vsync=0 iff vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [771,776].
//  - blank=1 iff hcount>=H_ACTIVE or vcount>=V_ACTIVE.
//  - frame_tick=1 for exactly one cycle per frame: the cycle showing (0,768).
//    frame_count increments in that same cycle.
//  - Delay line: a PIPE_DELAY-stage shift register on {hsync,vsync,blank}.
//    It shifts only when run=1, so *_dly equals the undelayed value PIPE_DELAY advancing cycles earlier.
//  - run=0: counters, syncs, delay line, frame_count and test_pixel all hold.
//    frame_tick is forced to 0 while run=0. It is not re-issued when run returns to 1.
//  - Reset asserted mid-frame: all outputs go to their reset values immediately (async).
//    After release the raster restarts at (0,0) on the first clock edge with run=1.
//  - Arithmetic is unsigned with no overflow, because H_TOTAL<2048 and V_TOTAL<1024.
//    Parameter sums must fit the port widths; an elaboration check enforces this.
// CONFIGURATION
//  XVGA_TEST_PATTERN_EN defined:
//    - test_pixel shows 8 vertical bars, each 128 px wide, selected by hcount[9:7].
//    - Bar colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
//    - test_pixel=000 whenever blank=1.
//  XVGA_TEST_PATTERN_EN undefined: test_pixel is tied to 12'h000 and no bar logic is built.
// TESTING
//  1. Release reset with run=1 and run 1344 cycles -> hcount 0..1343 then 0; vcount 0->1.
//     hsync low for exactly 136 cycles, starting at hcount=1048.
//  2. Run one full frame (1,083,264 cycles) -> exactly one frame_tick, at (0,768).
//     vsync low for lines 771..776 (6x1344 cycles). frame_count goes 0->1.
//  3. With PIPE_DELAY=2 -> blank_dly falls exactly 2 cycles after blank falls at (0,0) of frame 2.
//     The same 2-cycle offset holds at the hcount 1023->1024 blank edge.
//  4. Drop run to 0 at (500,300) for 50 cycles -> all outputs stay frozen at (500,300).
//     The raster resumes at (501,300) on the first cycle after run returns to 1.
//  5. Assert reset_n=0 at (1100,772) -> outputs go to reset values with no clock edge.
//     hsync_dly=1 and blank_dly=1 immediately.
//  6. With XVGA_TEST_PATTERN_EN -> (130,10) gives FF0 and (1023,767) gives 000.
//     (1030,10) gives 000 (blanked). Without the macro, test_pixel reads 000 at every pixel.

Source files
------------

// File: rtl/xvga_timing.sv
// rtl/xvga_timing.sv - 1024x768@60 raster timing source with delayed sync/blank and frame tick
// Optional colour-bar test pixel is built only when XVGA_TEST_PATTERN_EN is defined.
module xvga_timing #(
  parameter int H_ACTIVE   = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 160,
  parameter int V_ACTIVE   = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29,
  parameter int PIPE_DELAY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        hsync_dly,
  output logic        vsync_dly,
  output logic        blank_dly,
  output logic        frame_tick,
  output logic [7:0]  frame_count,
  output logic [11:0] test_pixel
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 1024 || PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_param
      $error("xvga_timing: raster totals exceed counter widths or PIPE_DELAY outside 1..8");
    end
  endgenerate

  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_blank;
  logic        r_frame_tick;
  logic [7:0]  r_frame_count;
  logic [2:0]  r_pipe [PIPE_DELAY];

  logic [10:0] w_h_nxt;
  logic [9:0]  w_v_nxt;
  logic        w_hsync_nxt;
  logic        w_vsync_nxt;
  logic        w_blank_nxt;
  logic        w_tick_nxt;

  // Decode from the next counter values so sync/blank land in the same cycle as their position.
  always_comb begin
    w_h_nxt = (r_hcount == H_LAST) ? 11'd0 : r_hcount + 11'd1;
    w_v_nxt = r_vcount;
    if (r_hcount == H_LAST) begin
      w_v_nxt = (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
    end
    w_hsync_nxt = !((w_h_nxt >= HS_FIRST) && (w_h_nxt <= HS_LAST));
    w_vsync_nxt = !((w_v_nxt >= VS_FIRST) && (w_v_nxt <= VS_LAST));
    w_blank_nxt = (w_h_nxt >= H_ACT) || (w_v_nxt >= V_ACT);
    w_tick_nxt  = (w_h_nxt == 11'd0) && (w_v_nxt == V_ACT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hcount      <= 11'd0;
      r_vcount      <= 10'd0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank       <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_frame_count <= 8'd0;
    end else if (run) begin
      r_hcount     <= w_h_nxt;
      r_vcount     <= w_v_nxt;
      r_hsync      <= w_hsync_nxt;
      r_vsync      <= w_vsync_nxt;
      r_blank      <= w_blank_nxt;
      r_frame_tick <= w_tick_nxt;
      if (w_tick_nxt) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end else begin
      r_frame_tick <= 1'b0;
    end
  end

  // Stage 0 captures the currently visible undelayed values, so the last stage lags by PIPE_DELAY advances.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        r_pipe[i] <= 3'b111;
      end
    end else if (run) begin
      r_pipe[0] <= {r_hsync, r_vsync, r_blank};
      for (int i = 1; i < PIPE_DELAY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

`ifdef XVGA_TEST_PATTERN_EN
  logic [11:0] r_test_pixel;
  logic [11:0] w_pixel_nxt;

  always_comb begin
    w_pixel_nxt = 12'h000;
    if (!w_blank_nxt) begin
      case (w_h_nxt[9:7])
        3'd0:    w_pixel_nxt = 12'hFFF;
        3'd1:    w_pixel_nxt = 12'hFF0;
        3'd2:    w_pixel_nxt = 12'h0FF;
        3'd3:    w_pixel_nxt = 12'h0F0;
        3'd4:    w_pixel_nxt = 12'hF0F;
        3'd5:    w_pixel_nxt = 12'hF00;
        3'd6:    w_pixel_nxt = 12'h00F;
        default: w_pixel_nxt = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_test_pixel <= 12'h000;
    end else if (run) begin
      r_test_pixel <= w_pixel_nxt;
    end
  end

  assign test_pixel = r_test_pixel;
`else
  assign test_pixel = 12'h000;
`endif

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank       = r_blank;
  assign frame_tick  = r_frame_tick;
  assign frame_count = r_frame_count;
  assign {hsync_dly, vsync_dly, blank_dly} = r_pipe[PIPE_DELAY-1];

endmodule

// File: tb/tb_xvga_timing.sv
// tb/tb_xvga_timing.sv - self-checking bench for xvga_timing against a linear-position raster model
// Full horizontal timing, shortened vertical timing so whole frames fit the cycle budget.
module tb_xvga_timing;

  localparam int H_ACTIVE = 1024, H_FP = 24, H_SYNC = 136, H_BP = 160;
  localparam int V_ACTIVE = 12, V_FP = 2, V_SYNC = 3, V_BP = 3;
  localparam int PIPE_DELAY = 2;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOTAL * V_TOTAL;
  localparam logic [47:0] RESET_VEC = {11'd0, 10'd0, 3'b110, 3'b111, 1'b0, 8'd0, 12'h000};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank;
  logic        hsync_dly, vsync_dly, blank_dly;
  logic        frame_tick;
  logic [7:0]  frame_count;
  logic [11:0] test_pixel;

  xvga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIPE_DELAY(PIPE_DELAY)
  ) dut (
    .clock(clock), .reset_n(reset_n), .run(run),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync), .blank(blank),
    .hsync_dly(hsync_dly), .vsync_dly(vsync_dly), .blank_dly(blank_dly),
    .frame_tick(frame_tick), .frame_count(frame_count), .test_pixel(test_pixel)
  );

  always #5 clock = ~clock;

  wire [47:0] act_vec = {hcount, vcount, hsync, vsync, blank, hsync_dly, vsync_dly, blank_dly,
                         frame_tick, frame_count, test_pixel};

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: raster position as a single index into the frame.
  int          m_p;
  logic        m_tick;
  int          m_fc;
  logic [11:0] m_pix;
  logic [2:0]  m_dq [$];

  function automatic logic [2:0] exp_sync(input int p);
    int h, v;
    h = p % H_TOTAL;
    v = p / H_TOTAL;
    exp_sync[2] = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
    exp_sync[1] = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
    exp_sync[0] = (h >= H_ACTIVE) || (v >= V_ACTIVE);
  endfunction

  function automatic logic [11:0] exp_pix(input int p);
    logic [2:0] s;
    s = exp_sync(p);
    exp_pix = 12'h000;
`ifdef XVGA_TEST_PATTERN_EN
    if (!s[0]) begin
      case ((p % H_TOTAL) / 128)
        0: exp_pix = 12'hFFF;
        1: exp_pix = 12'hFF0;
        2: exp_pix = 12'h0FF;
        3: exp_pix = 12'h0F0;
        4: exp_pix = 12'hF0F;
        5: exp_pix = 12'hF00;
        6: exp_pix = 12'h00F;
        default: exp_pix = 12'h000;
      endcase
    end
`endif
  endfunction

  function automatic logic [47:0] exp_vec();
    logic [2:0] s;
    s = exp_sync(m_p);
    return {11'(m_p % H_TOTAL), 10'(m_p / H_TOTAL), s, m_dq[0], m_tick, 8'(m_fc), m_pix};
  endfunction

  task automatic model_reset();
    m_p = 0;
    m_tick = 1'b0;
    m_fc = 0;
    m_pix = 12'h000;
    m_dq.delete();
    for (int i = 0; i < PIPE_DELAY; i++) m_dq.push_back(3'b111);
  endtask

  task automatic step(input logic rv);
    run = rv;
    @(posedge clock);
    #1;
    if (rv) begin
      m_dq.push_back(exp_sync(m_p));
      void'(m_dq.pop_front());
      m_p = (m_p + 1) % FRAME;
      m_tick = (m_p == V_ACTIVE * H_TOTAL);
      if (m_tick) m_fc = (m_fc + 1) % 256;
      m_pix = exp_pix(m_p);
    end else begin
      m_tick = 1'b0;
    end
  endtask

  task automatic goto(input int h, input int v);
    for (int i = 0; i < FRAME && m_p != v * H_TOTAL + h; i++) step(1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    run = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if (act_vec !== RESET_VEC) $display("FAIL reset_state: got %h expected %h", act_vec, RESET_VEC);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_line();
    int low, first;
    low = 0;
    first = -1;
    for (int i = 0; i < H_TOTAL; i++) begin
      step(1'b1);
      n_checks++;
      if (hcount !== 11'(m_p % H_TOTAL)) $display("FAIL line_hcount: got %0d expected %0d", hcount, m_p % H_TOTAL);
      else n_pass++;
      if (hsync === 1'b0) begin
        if (low == 0) first = hcount;
        low++;
      end
    end
    n_checks++;
    if (hcount !== 11'd0 || vcount !== 10'd1) $display("FAIL line_wrap: got (%0d,%0d) expected (0,1)", hcount, vcount);
    else n_pass++;
    n_checks++;
    if (low != 136) $display("FAIL hsync_width: got %0d expected 136", low);
    else n_pass++;
    n_checks++;
    if (first != 1048) $display("FAIL hsync_start: got %0d expected 1048", first);
    else n_pass++;
  endtask

  task automatic test_frame();
    int ticks, tick_h, tick_v, vs_low;
    ticks = 0; tick_h = -1; tick_v = -1; vs_low = 0;
    for (int i = 0; i < FRAME && m_p != 0; i++) begin
      step(1'b1);
      n_checks++;
      if (act_vec !== exp_vec()) $display("FAIL frame_vec: got %h expected %h", act_vec, exp_vec());
      else n_pass++;
      if (frame_tick === 1'b1) begin
        ticks++;
        tick_h = hcount;
        tick_v = vcount;
      end
      if (vsync === 1'b0) vs_low++;
    end
    n_checks++;
    if (ticks != 1) $display("FAIL tick_count: got %0d expected 1", ticks);
    else n_pass++;
    n_checks++;
    if (tick_h != 0 || tick_v != V_ACTIVE) $display("FAIL tick_pos: got (%0d,%0d) expected (0,%0d)", tick_h, tick_v, V_ACTIVE);
    else n_pass++;
    n_checks++;
    if (vs_low != V_SYNC * H_TOTAL) $display("FAIL vsync_width: got %0d expected %0d", vs_low, V_SYNC * H_TOTAL);
    else n_pass++;
    n_checks++;
    if (frame_count !== 8'd1) $display("FAIL frame_count: got %0d expected 1", frame_count);
    else n_pass++;
  endtask

  task automatic test_pipe();
    n_checks++;
    if (hcount !== 11'd0 || vcount !== 10'd0 || blank !== 1'b0 || blank_dly !== 1'b1)
      $display("FAIL pipe_f0: got (%0d,%0d) blank=%b dly=%b expected (0,0) 0 1", hcount, vcount, blank, blank_dly);
    else n_pass++;
    step(1'b1);
    n_checks++;
    if (blank_dly !== 1'b1) $display("FAIL pipe_f1: got %b expected 1", blank_dly);
    else n_pass++;
    step(1'b1);
    n_checks++;
    if (blank_dly !== 1'b0) $display("FAIL pipe_f2: got %b expected 0", blank_dly);
    else n_pass++;
    goto(1024, 0);
    n_checks++;
    if (blank !== 1'b1 || blank_dly !== 1'b0) $display("FAIL pipe_r0: got blank=%b dly=%b expected 1 0", blank, blank_dly);
    else n_pass++;
    step(1'b1);
    n_checks++;
    if (blank_dly !== 1'b0) $display("FAIL pipe_r1: got %b expected 0", blank_dly);
    else n_pass++;
    step(1'b1);
    n_checks++;
    if (blank_dly !== 1'b1) $display("FAIL pipe_r2: got %b expected 1", blank_dly);
    else n_pass++;
  endtask

  task automatic test_freeze();
    logic [47:0] snap;
    goto(500, 5);
    snap = act_vec;
    n_checks++;
    if (hcount !== 11'd500 || vcount !== 10'd5) $display("FAIL freeze_pos: got (%0d,%0d) expected (500,5)", hcount, vcount);
    else n_pass++;
    for (int i = 0; i < 50; i++) begin
      step(1'b0);
      n_checks++;
      if (act_vec !== snap) $display("FAIL freeze_hold: got %h expected %h", act_vec, snap);
      else n_pass++;
    end
    step(1'b1);
    n_checks++;
    if (hcount !== 11'd501 || vcount !== 10'd5 || act_vec !== exp_vec())
      $display("FAIL freeze_resume: got %h expected %h", act_vec, exp_vec());
    else n_pass++;
    goto(0, V_ACTIVE);
    n_checks++;
    if (frame_tick !== 1'b1 || frame_count !== 8'd2) $display("FAIL tick2: got tick=%b fc=%0d expected 1 2", frame_tick, frame_count);
    else n_pass++;
    step(1'b0);
    n_checks++;
    if (frame_tick !== 1'b0 || frame_count !== 8'd2) $display("FAIL tick_stall: got tick=%b fc=%0d expected 0 2", frame_tick, frame_count);
    else n_pass++;
    step(1'b1);
    n_checks++;
    if (frame_tick !== 1'b0 || hcount !== 11'd1 || frame_count !== 8'd2)
      $display("FAIL tick_noreissue: got tick=%b h=%0d fc=%0d expected 0 1 2", frame_tick, hcount, frame_count);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    goto(1100, V_ACTIVE + V_FP + 1);
    n_checks++;
    if (hsync !== 1'b0 || vsync !== 1'b0 || blank !== 1'b1) $display("FAIL pre_reset: got %b%b%b expected 001", hsync, vsync, blank);
    else n_pass++;
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (act_vec !== RESET_VEC) $display("FAIL async_reset: got %h expected %h", act_vec, RESET_VEC);
    else n_pass++;
    run = 1'b1;
    @(posedge clock);
    #1;
    n_checks++;
    if (act_vec !== RESET_VEC) $display("FAIL reset_hold: got %h expected %h", act_vec, RESET_VEC);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    step(1'b1);
    n_checks++;
    if (hcount !== 11'd1 || vcount !== 10'd0 || act_vec !== exp_vec())
      $display("FAIL reset_restart: got %h expected %h", act_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_pattern();
    logic [11:0] e;
`ifdef XVGA_TEST_PATTERN_EN
    e = 12'hFF0;
`else
    e = 12'h000;
`endif
    goto(130, 10);
    n_checks++;
    if (test_pixel !== e) $display("FAIL pix_130_10: got %h expected %h", test_pixel, e);
    else n_pass++;
`ifdef XVGA_TEST_PATTERN_EN
    e = 12'h0FF;
`endif
    goto(300, 10);
    n_checks++;
    if (test_pixel !== e) $display("FAIL pix_300_10: got %h expected %h", test_pixel, e);
    else n_pass++;
    goto(1030, 10);
    n_checks++;
    if (test_pixel !== 12'h000) $display("FAIL pix_blanked: got %h expected 000", test_pixel);
    else n_pass++;
`ifdef XVGA_TEST_PATTERN_EN
    e = 12'h00F;
`endif
    goto(800, 11);
    n_checks++;
    if (test_pixel !== e) $display("FAIL pix_800_11: got %h expected %h", test_pixel, e);
    else n_pass++;
    goto(1023, V_ACTIVE - 1);
    n_checks++;
    if (test_pixel !== 12'h000 || blank !== 1'b0) $display("FAIL pix_last: got %h blank=%b expected 000 0", test_pixel, blank);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      n_checks++;
      if (act_vec !== exp_vec()) $display("FAIL random_vec: got %h expected %h", act_vec, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_pipe();
    test_freeze();
    test_async_reset();
    test_pattern();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
